// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer sharing one sram_controller between a CPU port (A)
// and a DMA port (B), with a timeout guard against a hung controller.
module sram_arbiter #(
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pa_req,
  input  logic        pa_we,
  input  logic [16:0] pa_addr,
  input  logic [15:0] pa_wdata,
  output logic [15:0] pa_rdata,
  output logic        pa_ack,
  output logic        pa_err,
  input  logic        pb_req,
  input  logic        pb_we,
  input  logic [16:0] pb_addr,
  input  logic [15:0] pb_wdata,
  output logic [15:0] pb_rdata,
  output logic        pb_ack,
  output logic        pb_err,
  output logic        ctl_read_req,
  output logic        ctl_write_req,
  output logic [16:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  input  logic [15:0] ctl_rdata,
  input  logic        ctl_ready,
  output logic        busy,
  output logic        grant_b
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e             state_q;
  logic               last_b_q;
  logic               we_q;
  logic               grant_b_q;
  logic               busy_q;
  logic               rd_req_q;
  logic               wr_req_q;
  logic [16:0]        addr_q;
  logic [15:0]        wdata_q;
  logic [15:0]        pa_rdata_q;
  logic [15:0]        pb_rdata_q;
  logic               pa_ack_q;
  logic               pb_ack_q;
  logic               pa_err_q;
  logic               pb_err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pick_b;
  logic               win_we;
  logic [16:0]        win_addr;
  logic [15:0]        win_wdata;

  // On a tie, round-robin favours the port that did not own the last transaction.
  always_comb begin
    pick_b = pb_req;
    if (pa_req && pb_req) begin
      pick_b = (ARB_MODE != 0) && !last_b_q;
    end
    win_we    = pick_b ? pb_we    : pa_we;
    win_addr  = pick_b ? pb_addr  : pa_addr;
    win_wdata = pick_b ? pb_wdata : pa_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      we_q       <= 1'b0;
      grant_b_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pa_rdata_q <= '0;
      pb_rdata_q <= '0;
      pa_ack_q   <= 1'b0;
      pb_ack_q   <= 1'b0;
      pa_err_q   <= 1'b0;
      pb_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pa_req || pb_req) begin
            grant_b_q <= pick_b;
            we_q      <= win_we;
            addr_q    <= win_addr;
            wdata_q   <= win_wdata;
            rd_req_q  <= !win_we;
            wr_req_q  <= win_we;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_req_q <= 1'b0;
          wr_req_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // ctl_ready is checked first so a completion on the limit cycle is not an error.
          if (ctl_ready) begin
            if (!we_q) begin
              if (grant_b_q) pb_rdata_q <= ctl_rdata;
              else           pa_rdata_q <= ctl_rdata;
            end
            pa_ack_q <= !grant_b_q;
            pb_ack_q <= grant_b_q;
            state_q  <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (grant_b_q) pb_rdata_q <= '1;
            else           pa_rdata_q <= '1;
            pa_ack_q <= !grant_b_q;
            pb_ack_q <= grant_b_q;
            pa_err_q <= !grant_b_q;
            pb_err_q <= grant_b_q;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          pa_ack_q <= 1'b0;
          pb_ack_q <= 1'b0;
          pa_err_q <= 1'b0;
          pb_err_q <= 1'b0;
          last_b_q <= grant_b_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pa_rdata      = pa_rdata_q;
  assign pa_ack        = pa_ack_q;
  assign pa_err        = pa_err_q;
  assign pb_rdata      = pb_rdata_q;
  assign pb_ack        = pb_ack_q;
  assign pb_err        = pb_err_q;
  assign ctl_read_req  = rd_req_q;
  assign ctl_write_req = wr_req_q;
  assign ctl_addr      = addr_q;
  assign ctl_wdata     = wdata_q;
  assign busy          = busy_q;
  assign grant_b       = grant_b_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer that shares one sram_controller (128K x 16 external SRAM) between two requesters.
- Port A is the CPU side; port B is the video/loader DMA side.
- Per port: latches the request, issues a single-cycle read_req/write_req pulse to the controller, waits for the controller's ready completion pulse, then returns read data and a one-cycle ack to the granted port.
- A timeout guard stops a hung controller from locking either port.

Parameters:
- ARB_MODE, 1, 0 = fixed priority (A always wins ties), 1 = round-robin (the port not granted last wins ties).
- TIMEOUT_CYCLES, 255, number of WAIT cycles without ctl_ready before the transaction is aborted with error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pa_req  in  1  port A request, level; held until pa_ack
- pa_we  in  1  port A: 1 = write, 0 = read
- pa_addr  in  17  port A word address
- pa_wdata  in  16  port A write data
- pa_rdata  out  16  port A read data, valid while pa_ack=1
- pa_ack  out  1  port A completion pulse
- pa_err  out  1  port A timeout flag, valid with pa_ack
- pb_req, pb_we, pb_addr, pb_wdata, pb_rdata, pb_ack, pb_err  same as port A, for port B
- ctl_read_req  out  1  to sram_controller read_req
- ctl_write_req  out  1  to sram_controller write_req
- ctl_addr  out  17  to sram_controller addr_in
- ctl_wdata  out  16  to sram_controller write_data
- ctl_rdata  in  16  from sram_controller read_data
- ctl_ready  in  1  from sram_controller ready (completion pulse)
- busy  out  1  high in every state except IDLE
- grant_b  out  1  0 = port A owns the current or last transaction, 1 = port B

Behaviour:
- Reset (async, active-high): state = IDLE. All outputs are 0; rdata registers = 16'h0000. last_grant = B, so port A wins the first round-robin tie. Timeout counter = 0. ctl_*_req deassert immediately, even mid-transaction.
- All outputs are registered.
- FSM state IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick the winner. Only one port requesting: that port wins. Both requesting: ARB_MODE=0 picks A; ARB_MODE=1 picks the port not equal to last_grant.
  - Latch the winner's we/addr/wdata into ctl_addr/ctl_wdata and an internal we bit. Set grant_b. Go to ISSUE.
- FSM state ISSUE:
  - Assert ctl_read_req (we=0) or ctl_write_req (we=1) for exactly one cycle.
  - Clear the timeout counter. Go to WAIT.
- FSM state WAIT:
  - ctl_*_req are low.
  - ctl_ready=1: capture ctl_rdata (reads only; writes leave rdata unchanged) and go to DONE with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1, go to DONE with err=1 and rdata=16'hFFFF.
- FSM state DONE:
  - Pulse the granted port's ack for one cycle, with err valid. The other port's ack stays 0.
  - Update last_grant. Go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> ctl req at cycle 1 -> ctl_ready at cycle k >= 2 -> ack at cycle k+1. Best case is 4 cycles request to ack.
- Handshake:
  - A transaction completes at the rising edge where req and ack are both 1.
  - The requester holds we/addr/wdata stable while req is high.
  - Keeping req high after ack issues a new request, arbitrated in the next IDLE cycle.
- Boundary conditions:
  - ctl_ready outside WAIT is ignored.
  - Requester drops req mid-transaction: the transaction still completes and ack still pulses.
  - Loser's req held across transactions: under ARB_MODE=1 it wins the next arbitration. No starvation.
  - ctl_ready in the same cycle the counter reaches its limit: success wins (err=0).
  - Address and data are passed unmodified, no width conversion. Addresses 17'h1FFFF and 17'h00000 both pass through.

Test Plan:
- Port A writes 16'h1234 to 17'h0010, then reads 17'h0010 -> ctl_write_req then ctl_read_req are single-cycle pulses; pa_ack pulses once per transaction; read returns pa_rdata=16'h1234 with pa_err=0; pb_ack stays 0.
- pa_req and pb_req asserted in the same cycle, ARB_MODE=1, both held for 4 transactions -> grant order A,B,A,B.
- Same stimulus with ARB_MODE=0 -> A wins each tie; B is granted only after pa_req drops.
- Controller model never returns ready, TIMEOUT_CYCLES=16 -> ack 17 cycles after ctl req, with err=1 and rdata=16'hFFFF; busy returns to 0 the cycle after.
- rst asserted while in WAIT -> all outputs 0 asynchronously, with no ack. After release, a port-B read of 17'h1FFFF completes normally with pb_err=0.
- Back-to-back port-B reads of 17'h00000 and 17'h00001 with zero-wait ready (ctl_ready in the cycle after ctl req) -> acks exactly 4 cycles apart.
